fsm_overlay_ctrl: RTL and testbench

- Memory-mapped controller for the FSM overlay. It sits downstream of the picorv32 native memory port, in parallel with the Wishbone path, inside user_project_wrapper.
- Holds a programmable 16-state x 4-input transition table and steps the overlay FSM from an external 2-bit input.
- Drives fsm_config[3:0], the per-state output, which is consumed by fsm_overlay.

---
 rtl/fsm_overlay_ctrl.sv | 159 +++++++++++++++
 tb/tb_fsm_overlay_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fsm_overlay_ctrl.sv
// Memory-mapped controller for the FSM overlay: 16x4 transition table, prescaled stepping, 1-cycle bus ack.
// Define FSM_OVERLAY_IRQ_EN to add the irq port with IRQ_MASK/IRQ_PEND registers.
module fsm_overlay_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,  // must be 512-byte aligned
  parameter int unsigned TICK_DIV    = 16,
  parameter logic [3:0]  RESET_STATE = 4'd0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic [1:0]  fsm_in,
  output logic [3:0]  fsm_config,
  output logic [3:0]  fsm_state
`ifdef FSM_OVERLAY_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic {IDLE, ACK} bus_st_e;

  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

  bus_st_e     bus_st, bus_nxt;
  logic        hit, acc, wr, rd;
  logic [6:0]  word;
  logic        run;
  logic [15:0] presc;
  logic [31:0] cycles;
  logic [1:0]  last_in;
  logic [7:0]  tbl [64];
  logic [7:0]  entry;
  logic        ctrl_wr, step_ev, clr_ev, run_d, run_tick, tick;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign hit  = mem_valid && (mem_addr[31:9] == BASE_ADDR[31:9]);
  assign word = mem_addr[8:2];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) bus_st <= IDLE;
    else          bus_st <= bus_nxt;
  end

  // Accepting only from IDLE keeps a request held through the ACK cycle from being taken twice.
  always_comb begin
    bus_nxt = bus_st;
    acc     = 1'b0;
    case (bus_st)
      IDLE: if (hit) begin
        acc     = 1'b1;
        bus_nxt = ACK;
      end
      ACK:     bus_nxt = IDLE;
      default: bus_nxt = IDLE;
    endcase
  end

  assign mem_ready = (bus_st == ACK);
  assign wr        = acc && (|mem_wstrb);
  assign rd        = acc && !(|mem_wstrb);

  assign ctrl_wr  = wr && (word == 7'h00) && mem_wstrb[0];
  assign step_ev  = ctrl_wr && mem_wdata[1] && !run;
  assign clr_ev   = ctrl_wr && mem_wdata[2];
  assign run_d    = ctrl_wr ? mem_wdata[0] : run;
  assign run_tick = run && (presc == DIV_LAST) && run_d;
  assign tick     = (run_tick || step_ev) && !clr_ev;
  assign entry    = tbl[{fsm_state, fsm_in}];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      run        <= 1'b0;
      presc      <= '0;
      cycles     <= '0;
      fsm_state  <= RESET_STATE;
      fsm_config <= '0;
      last_in    <= '0;
    end else begin
      run <= run_d;
      // Counting starts only on the edge after run is seen high, so the first tick lands TICK_DIV cycles later.
      if (clr_ev || !run || !run_d || (presc == DIV_LAST)) presc <= '0;
      else                                                presc <= presc + 16'd1;
      if (wr && (word == 7'h02)) cycles <= '0;
      else if (tick)             cycles <= cycles + 32'd1;
      if (clr_ev) begin
        fsm_state  <= RESET_STATE;
        fsm_config <= '0;
      end else if (tick) begin
        fsm_state  <= entry[3:0];
        fsm_config <= entry[7:4];
        last_in    <= fsm_in;
      end
    end
  end

  // entry is read combinationally, so a same-cycle table write is seen only by the next tick.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < 64; i++) tbl[i] <= 8'h00;
    end else if (wr && mem_addr[8] && mem_wstrb[0]) begin
      tbl[mem_addr[7:2]] <= mem_wdata[7:0];
    end
  end

`ifdef FSM_OVERLAY_IRQ_EN
  logic [15:0] irq_mask;
  logic        irq_pend, pend_set, pend_clr;

  assign pend_set = tick && irq_mask[entry[3:0]];
  assign pend_clr = wr && (word == 7'h05) && mem_wstrb[0] && mem_wdata[0];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_mask <= '0;
      irq_pend <= 1'b0;
    end else begin
      if (wr && (word == 7'h04)) begin
        if (mem_wstrb[0]) irq_mask[7:0]  <= mem_wdata[7:0];
        if (mem_wstrb[1]) irq_mask[15:8] <= mem_wdata[15:8];
      end
      irq_pend <= pend_set || (irq_pend && !pend_clr);
    end
  end

  assign irq = irq_pend;
`endif

  always_comb begin
    rd_val = '0;
    if (mem_addr[8]) begin
      rd_val = {24'b0, tbl[mem_addr[7:2]]};
    end else begin
      case (word)
        7'h00:   rd_val = {31'b0, run};
        7'h01:   rd_val = {21'b0, last_in, run, fsm_config, fsm_state};
        7'h02:   rd_val = cycles;
`ifdef FSM_OVERLAY_IRQ_EN
        7'h04:   rd_val = {16'b0, irq_mask};
        7'h05:   rd_val = {31'b0, irq_pend};
`endif
        default: rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) mem_rdata <= '0;
    else          mem_rdata <= rd ? rd_val : 32'h0;
  end

  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:8]};

endmodule

// File: tb/tb_fsm_overlay_ctrl.sv
// Directed bench for fsm_overlay_ctrl: bus timing, stepping, prescaled run, corner collisions, reset.
module tb_fsm_overlay_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] CTRL = BASE + 32'h000, STAT = BASE + 32'h004, CYC = BASE + 32'h008;

  logic        wb_clk_i = 1'b0, wb_rst_i = 1'b1;
  logic        mem_valid = 1'b0, mem_ready;
  logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
  logic [3:0]  mem_wstrb = '0;
  logic [1:0]  fsm_in = '0;
  logic [3:0]  fsm_config, fsm_state;
`ifdef FSM_OVERLAY_IRQ_EN
  logic        irq;
`endif

  int checks = 0, errors = 0, cyc = 0, t0;
  logic [31:0] d;

  fsm_overlay_ctrl dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .fsm_in(fsm_in), .fsm_config(fsm_config), .fsm_state(fsm_state)
`ifdef FSM_OVERLAY_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // at<0: issue at the next negedge; otherwise the request is accepted on edge number 'at'.
  task automatic xfer(input int at, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rdat);
    if (at < 0) @(negedge wb_clk_i);
    else begin
      while (cyc < at - 1) @(negedge wb_clk_i);
      chk("sched", cyc, at - 1);
    end
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = st;
    @(posedge wb_clk_i); #1;
    mem_valid = 1'b0; mem_wstrb = '0;
    chk("ready_n1", {31'b0, mem_ready}, 32'd1);
    rdat = mem_rdata;
    @(posedge wb_clk_i); #1;
    chk("ready_n2", {31'b0, mem_ready}, 32'd0);
  endtask

  task automatic wr(input int at, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] dummy;
    xfer(at, a, wd, 4'hF, dummy);
  endtask

  task automatic rd(input int at, input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] r;
    xfer(at, a, 32'h0, 4'h0, r);
    chk(tag, r, exp);
  endtask

  task automatic at_neg(input int n);
    while (cyc < n) @(negedge wb_clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i); wb_rst_i = 1'b0;
    chk("rst_state", {28'b0, fsm_state}, 32'd0);
    chk("rst_cfg", {28'b0, fsm_config}, 32'd0);
    chk("rst_ready", {31'b0, mem_ready}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    rd(-1, STAT, 32'h0, "status_rst");

    // Single step through entry 0
    wr(-1, BASE + 32'h100, 32'h35);
    wr(-1, CTRL, 32'h2);
    chk("step_state", {28'b0, fsm_state}, 32'd5);
    chk("step_cfg", {28'b0, fsm_config}, 32'd3);
    rd(-1, CYC, 32'd1, "cycles_1");
    rd(-1, STAT, 32'h35, "status_step");
    rd(-1, BASE + 32'h100, 32'h35, "tbl_rd");

    // Self-loop in state 5, then run with TICK_DIV=16
    for (int i = 0; i < 4; i++) wr(-1, BASE + 32'h150 + 32'(4 * i), 32'h05);
    t0 = cyc + 2;
    wr(t0, CTRL, 32'h1);
    at_neg(t0 + 15);
    chk("pre_tick_cfg", {28'b0, fsm_config}, 32'd3);
    rd(t0 + 16, CYC, 32'd1, "cyc_t16");
    chk("tick16_cfg", {28'b0, fsm_config}, 32'd0);
    rd(t0 + 18, CYC, 32'd2, "cyc_t18");
    rd(t0 + 32, CYC, 32'd2, "cyc_t32");
    rd(t0 + 34, CYC, 32'd3, "cyc_t34");
    chk("run_state", {28'b0, fsm_state}, 32'd5);
    rd(-1, CTRL, 32'd1, "ctrl_run");

    // Table write colliding with a tick on the same entry
    wr(t0 + 48, BASE + 32'h150, 32'h97);
    chk("rbw_old_state", {28'b0, fsm_state}, 32'd5);
    chk("rbw_old_cfg", {28'b0, fsm_config}, 32'd0);
    at_neg(t0 + 64);
    chk("rbw_new_state", {28'b0, fsm_state}, 32'd7);
    chk("rbw_new_cfg", {28'b0, fsm_config}, 32'd9);

    // run=0 written on a pending tick edge suppresses it
    wr(t0 + 80, CTRL, 32'h0);
    chk("stop_state", {28'b0, fsm_state}, 32'd7);
    rd(-1, CYC, 32'd5, "cyc_stop");
    rd(-1, STAT, 32'h97, "status_stop");

    // clear wins over step
    wr(-1, CTRL, 32'h6);
    chk("clr_state", {28'b0, fsm_state}, 32'd0);
    chk("clr_cfg", {28'b0, fsm_config}, 32'd0);
    rd(-1, CYC, 32'd5, "cyc_clr");

    // Non-zero input symbol
    fsm_in = 2'd2;
    wr(-1, BASE + 32'h108, 32'hA4);
    wr(-1, CTRL, 32'h2);
    rd(-1, STAT, 32'h4A4, "status_in2");
    wr(-1, CYC, 32'h1234);
    rd(-1, CYC, 32'd0, "cyc_wclr");

    // Unmapped in-window offsets
    wr(-1, BASE + 32'h00C, 32'hFFFF_FFFF);
    rd(-1, BASE + 32'h00C, 32'h0, "hole_00c");
    rd(-1, BASE + 32'h0FC, 32'h0, "hole_0fc");
`ifndef FSM_OVERLAY_IRQ_EN
    wr(-1, BASE + 32'h010, 32'hFFFF);
    rd(-1, BASE + 32'h010, 32'h0, "noirq_mask");
    rd(-1, BASE + 32'h014, 32'h0, "noirq_pend");
`endif

    // Request held into the ACK cycle is not taken twice
    @(negedge wb_clk_i);
    mem_valid = 1'b1; mem_addr = STAT; mem_wstrb = 4'h0;
    @(posedge wb_clk_i); #1;
    chk("hold_n1", {31'b0, mem_ready}, 32'd1);
    @(posedge wb_clk_i); #1;
    mem_valid = 1'b0;
    chk("hold_n2", {31'b0, mem_ready}, 32'd0);

    // Outside the window
    @(negedge wb_clk_i);
    mem_valid = 1'b1; mem_addr = BASE + 32'h200;
    for (int i = 0; i < 8; i++) begin
      @(negedge wb_clk_i);
      chk("miss_ready", {31'b0, mem_ready}, 32'd0);
    end
    mem_valid = 1'b0;

    // Reset during the ACK cycle of a read
    @(negedge wb_clk_i);
    mem_valid = 1'b1; mem_addr = STAT;
    @(posedge wb_clk_i); #1;
    mem_valid = 1'b0;
    chk("rstack_n1", {31'b0, mem_ready}, 32'd1);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    chk("rstack_ready", {31'b0, mem_ready}, 32'd0);
    chk("rstack_rdata", mem_rdata, 32'd0);
    chk("rstack_state", {28'b0, fsm_state}, 32'd0);
    chk("rstack_cfg", {28'b0, fsm_config}, 32'd0);
    @(negedge wb_clk_i); wb_rst_i = 1'b0;
    rd(-1, BASE + 32'h108, 32'h0, "rst_tbl");
    rd(-1, CTRL, 32'h0, "rst_ctrl");

`ifdef FSM_OVERLAY_IRQ_EN
    chk("irq_rst", {31'b0, irq}, 32'd0);
    fsm_in = 2'd0;
    wr(-1, BASE + 32'h100, 32'h35);
    wr(-1, BASE + 32'h010, 32'h0020);
    wr(-1, CTRL, 32'h2);
    chk("irq_set", {31'b0, irq}, 32'd1);
    rd(-1, BASE + 32'h014, 32'd1, "irq_pend_rd");
    rd(-1, BASE + 32'h010, 32'h20, "irq_mask_rd");
    wr(-1, BASE + 32'h014, 32'h1);
    chk("irq_clr", {31'b0, irq}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
